fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  - IF stage plus IF/ID pipeline register; directly upstream of the EX datapath, whose pc input is this block's pc_D.
//  - Owns the PC and drives a req/ready instruction-memory handshake, so wait-state memory or an I-cache can sit behind it.
//  - Honours hazard-unit stall and flush, EX-stage redirect, and buffers one instruction returned during a stall.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC fetched first after reset
//  NOP_INSTR  32'h0000_0013   value loaded into instr_D on reset/flush (addi x0,x0,0)
// PORTS
//  clk          in   1   core clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  stallD       in   1   hold IF/ID contents and PC this cycle
//  flushD       in   1   bubble IF/ID next edge
//  redirect     in   1   taken branch/jump resolved in EX
//  redirect_pc  in   32  target for redirect
//  imem_req     out  1   fetch request, held until imem_ready
//  imem_addr    out  32  fetch address, word aligned, stable while imem_req=1
//  imem_ready   in   1   imem_rdata valid this cycle; completes request
//  imem_rdata   in   32  fetched instruction
//  instr_D      out  32  IF/ID instruction
//  pc_D         out  32  IF/ID PC
//  valid_D      out  1   instr_D is a real instruction
// BEHAVIOUR
//  - Reset (reset=0, async): pc_F=RESET_PC, state=IDLE, imem_req=0, instr_D=NOP_INSTR, pc_D=0, valid_D=0, skid empty.
//  - FSM states: IDLE, FETCH, DROP.
//    IDLE: one cycle after reset release -> FETCH.
//    FETCH: imem_req=1, imem_addr=pc_F. On imem_ready with stallD=0 and skid empty: IF/ID <= {imem_rdata, pc_F, valid=1}, pc_F += 4.
//      On imem_ready with stallD=1: capture into skid buffer, pc_F += 4, imem_req=0 until skid drains.
//    DROP: entered on redirect while imem_req=1 and imem_ready=0. imem_req stays 1 (no retraction), imem_addr unchanged.
//      Returned data is discarded; then -> FETCH at the latched redirect target.
//  - Latency: instruction visible on instr_D the edge after imem_ready; zero-wait memory sustains 1 instr/cycle.
//  - Skid drain: with stallD=0 and skid full, IF/ID <= skid and skid empties. A new request issues in the same cycle.
//  - Redirect (any state): pc_F <= redirect_pc, skid cleared, IF/ID bubbled (same as flushD).
//    If imem_ready=1 in the same cycle, the data is discarded and the next request goes to redirect_pc with no DROP.
//  - flushD: IF/ID <= {NOP_INSTR, 0, 0}. Flush beats stallD when both are asserted. pc_F is unaffected unless redirect.
//  - stallD with no returned data: IF/ID and pc_F hold; an outstanding request stays asserted.
//  - Multiple redirects during DROP: the last target wins.
//  - PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 0. redirect_pc[1:0] is forced to 0.
//  - Reset asserted mid-request: everything returns to reset values immediately. imem_req drops asynchronously.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    - adds outputs perf_fetched[31:0] (count of instructions written to IF/ID with valid=1)
//      and perf_wait[31:0] (count of cycles with imem_req=1 and imem_ready=0)
//    - both counters wrap and reset to 0
//  FETCH_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Zero-wait memory, imem_ready=1: pc_D=0,4,8,C on consecutive cycles after the first fetch; valid_D=1 throughout.
//  2. 2 wait states per fetch: imem_req held, imem_addr stable 3 cycles; a new instr_D every 3 cycles.
//  3. stallD=1 for 3 cycles as data 32'h00A00093 returns: IF/ID holds the old value;
//     skid supplies 00A00093 on release; no instruction lost or duplicated.
//  4. redirect to 0x100 during a 2-wait request to 0x8: data discarded, next imem_addr=0x100, valid_D=0 for the bubble.
//  5. flushD and stallD together: instr_D=0x00000013, valid_D=0 next edge.
//  6. reset pulled low mid-request: imem_req=0 without a clock edge.
//     After release, the first imem_addr=RESET_PC; with FETCH_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage plus the IF/ID pipeline register.
//   Owns the fetch PC and drives a req/ready instruction-memory handshake, so
//   wait-state memory or an I-cache can sit behind it. Honours hazard-unit
//   stall/flush and EX-stage redirect, and parks one instruction returned
//   while ID is stalled in a single-entry skid buffer.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     defined   -> adds perf_fetched / perf_wait counters and output ports
//     undefined -> no counters, no extra ports
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  // Fetch-side state
  state_e      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] pc_q;

  // IF/ID register
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q,    ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Skid buffer
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q,    skid_pc_d;

  // Per-cycle decode
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;
  logic        hs;
  logic        fetch_hs;
  logic        advance;
  logic        bubble;
  logic        wr_valid;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc       = pc_q + 32'd4;            // wraps mod 2^32
  assign hs           = req_q & imem_ready;
  // Only a FETCH-state response is real; a DROP-state response is the stale
  // pre-redirect fetch, and a same-cycle redirect discards the response too.
  assign fetch_hs     = (state_q == FETCH) & hs & ~redirect;
  assign advance      = ~stallD & ~flushD;
  assign bubble       = flushD | redirect;
  assign wr_valid     = ~bubble & ~stallD & (skid_valid_q | fetch_hs);

  // IF/ID and skid next-state: bubble beats stall, skid drains before new data.
  // A response arriving while ID cannot take it (stall or flush) is parked in
  // the skid so the instruction stream stays intact; only redirect kills it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (bubble) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (!stallD) begin
      if (skid_valid_q) begin
        ifid_instr_d = skid_instr_q;
        ifid_pc_d    = skid_pc_q;
        ifid_valid_d = 1'b1;
      end else if (fetch_hs) begin
        ifid_instr_d = imem_rdata;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = 32'h0;
        ifid_valid_d = 1'b0;
      end
    end

    if (redirect) begin
      skid_valid_d = 1'b0;
    end else if (fetch_hs && !advance) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_rdata;
      skid_pc_d    = pc_q;
    end else if (skid_valid_q && advance) begin
      skid_valid_d = 1'b0;
    end
  end

  // Fetch FSM: PC, request and address are registered so imem_addr is stable
  // for the whole life of a request.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_tgt;
      if (req_q && !imem_ready) begin
        // Outstanding request cannot be retracted: wait it out in DROP.
        state_q <= DROP;
      end else begin
        state_q <= FETCH;
        req_q   <= 1'b1;
        addr_q  <= redirect_tgt;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (hs) begin
            pc_q <= pc_inc;
            if (advance) begin
              addr_q <= pc_inc;
            end else begin
              req_q <= 1'b0;             // response parked in skid; pause
            end
          end else if (!req_q && advance) begin
            req_q  <= 1'b1;              // skid drains this edge; resume
            addr_q <= pc_q;
          end
        end
        DROP: begin
          if (imem_ready) begin
            state_q <= FETCH;
            addr_q  <= pc_q;             // latched redirect target
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register and skid occupancy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Skid payload, qualified by skid_valid_q.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; its valid flag is reset instead,
    // which keeps reset fan-out to control state only.
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_wait_q;

  // Wrapping event counters: valid IF/ID writes and memory wait cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= 32'h0;
      perf_wait_q    <= 32'h0;
    end else begin
      if (wr_valid) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (req_q && !imem_ready) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`else
  logic unused_perf;
  assign unused_perf = wr_valid;
`endif

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr_D   = ifid_instr_q;
  assign pc_D      = ifid_pc_q;
  assign valid_D   = ifid_valid_q;

endmodule
